// File: rtl/alu_psr_pipe.sv
// Parametrised ALU with processor status register, registered output with
// valid/ready backpressure and an optional iterative shift-add multiplier.
module alu_psr_pipe #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [4:0]       flags_o,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  localparam int FC = 0, FL = 1, FF = 2, FZ = 3, FN = 4;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;
  logic [4:0]           flags_q, flags_d;
  logic [2*WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]     mp_q, mp_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SW-1:0]        cnt_q, cnt_d;

  logic                 accept, is_mul;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_err;
  logic [4:0]           alu_flags;
  logic [WIDTH:0]       add_full;
  logic [2*WIDTH-1:0]   shl_full, shr_full, mul_sum;
  logic [SW-1:0]        sh;

  assign in_ready  = rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && (op == 4'd8);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign flags_o   = flags_q;
  assign busy      = (state_q == MUL);

  // Single-cycle datapath; flags start from the current PSR so untouched bits hold.
  always_comb begin
    alu_flags = flags_q;
    alu_res   = '0;
    alu_err   = 1'b0;
    sh        = b[SW-1:0];
    add_full  = {1'b0, a} + {1'b0, b};
    // Widened shifts leave the last bit shifted out at a fixed position (0 for sh==0).
    shl_full  = {{WIDTH{1'b0}}, a} << sh;
    shr_full  = {a, {WIDTH{1'b0}}} >> sh;
    case (op)
      4'd0: begin
        alu_res       = add_full[WIDTH-1:0];
        alu_flags[FC] = add_full[WIDTH];
        alu_flags[FF] = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res       = a - b;
        alu_flags[FC] = (a < b);
        alu_flags[FF] = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: begin
        alu_res       = a;
        alu_flags[FL] = (a < b);
        alu_flags[FN] = ($signed(a) < $signed(b));
        alu_flags[FZ] = (a == b);
      end
      4'd3: alu_res = a & b;
      4'd4: alu_res = a | b;
      4'd5: alu_res = a ^ b;
      4'd6: begin
        alu_res       = shl_full[WIDTH-1:0];
        alu_flags[FC] = shl_full[WIDTH];
      end
      4'd7: begin
        alu_res       = shr_full[2*WIDTH-1:WIDTH];
        alu_flags[FC] = shr_full[WIDTH-1];
      end
      default: begin
        alu_err   = 1'b1;
        alu_flags = flags_q;
      end
    endcase
    if (!alu_err && op != 4'd2) begin
      alu_flags[FZ] = (alu_res == '0);
      alu_flags[FN] = alu_res[WIDTH-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    err_d       = err_q;
    flags_d     = flags_q;
    mc_d        = mc_q;
    mp_d        = mp_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_sum     = acc_q + (mp_q[0] ? mc_q : '0);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = MUL;
            mc_d    = {{WIDTH{1'b0}}, a};
            mp_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            err_d       = alu_err;
            flags_d     = alu_flags;
          end
        end
      end
      MUL: begin
        if (cnt_q != SW'(WIDTH - 1)) begin
          acc_d = mul_sum;
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
          cnt_d = cnt_q + 1'b1;
        // Final step waits for the output slot so a held result is never overwritten.
        end else if (!out_valid_q || out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_sum[WIDTH-1:0];
          err_d       = 1'b0;
          flags_d[FC] = |mul_sum[2*WIDTH-1:WIDTH];
          flags_d[FZ] = (mul_sum[WIDTH-1:0] == '0);
          flags_d[FN] = mul_sum[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      flags_q     <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      flags_q     <= flags_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule
